// File: rtl/fpga_robots_keycode_arbiter.sv
// Merges the PS/2 and serial key code streams into one strobe/data pair for the
// keyboard decoder, keeping E0/F0 prefix sequences atomic per source.
module fpga_robots_keycode_arbiter #(
  parameter int FIFO_AW        = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W           = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ps2_kc_dat,
  input  logic       ps2_kc_stb,
  input  logic [7:0] ser_kc_dat,
  input  logic       ser_kc_stb,
  output logic [7:0] kc_dat,
  output logic       kc_stb,
  output logic       kc_src,
  output logic       kc_abort,
  output logic       drop_ps2,
  output logic       drop_ser
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic SRC_PS2 = 1'b0;
  localparam logic SRC_SER = 1'b1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOCK_PS2, LOCK_SER} state_t;

  state_t          state, state_d;
  logic            last, last_d;
  logic [TO_W-1:0] to_cnt, to_d;
  logic            pop_ps2, pop_ser, abort_d;
  logic [7:0]      pop_dat;

  logic [7:0]       ps2_mem [DEPTH];
  logic [7:0]       ser_mem [DEPTH];
  logic [FIFO_AW:0] ps2_wr, ps2_rd, ser_wr, ser_rd;
  logic             ps2_empty, ps2_full, ser_empty, ser_full;
  logic             ps2_push, ser_push;
  logic [7:0]       ps2_head, ser_head;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == 8'hE0) || (b == 8'hF0);
  endfunction

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign ps2_empty = (ps2_wr == ps2_rd);
  assign ser_empty = (ser_wr == ser_rd);
  assign ps2_full  = (ps2_wr[FIFO_AW] != ps2_rd[FIFO_AW]) &&
                     (ps2_wr[FIFO_AW-1:0] == ps2_rd[FIFO_AW-1:0]);
  assign ser_full  = (ser_wr[FIFO_AW] != ser_rd[FIFO_AW]) &&
                     (ser_wr[FIFO_AW-1:0] == ser_rd[FIFO_AW-1:0]);
  assign ps2_head  = ps2_mem[ps2_rd[FIFO_AW-1:0]];
  assign ser_head  = ser_mem[ser_rd[FIFO_AW-1:0]];

  // A full FIFO still takes a byte when it is being popped in the same cycle.
  assign ps2_push = ps2_kc_stb && (!ps2_full || pop_ps2);
  assign ser_push = ser_kc_stb && (!ser_full || pop_ser);

  always_ff @(posedge clk) begin
    if (ps2_push) ps2_mem[ps2_wr[FIFO_AW-1:0]] <= ps2_kc_dat;
    if (ser_push) ser_mem[ser_wr[FIFO_AW-1:0]] <= ser_kc_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps2_wr <= '0;
      ps2_rd <= '0;
      ser_wr <= '0;
      ser_rd <= '0;
    end else begin
      if (ps2_push) ps2_wr <= ps2_wr + 1'b1;
      if (pop_ps2)  ps2_rd <= ps2_rd + 1'b1;
      if (ser_push) ser_wr <= ser_wr + 1'b1;
      if (pop_ser)  ser_rd <= ser_rd + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last   <= SRC_SER;
      to_cnt <= '0;
    end else begin
      state  <= state_d;
      last   <= last_d;
      to_cnt <= to_d;
    end
  end

  always_comb begin
    state_d = state;
    last_d  = last;
    to_d    = '0;
    pop_ps2 = 1'b0;
    pop_ser = 1'b0;
    abort_d = 1'b0;
    pop_dat = 8'h00;
    case (state)
      IDLE: begin
        if (!ps2_empty && (ser_empty || last == SRC_SER)) begin
          pop_ps2 = 1'b1;
          pop_dat = ps2_head;
        end else if (!ser_empty) begin
          pop_ser = 1'b1;
          pop_dat = ser_head;
        end
        if (pop_ps2 || pop_ser) begin
          if (is_prefix(pop_dat)) state_d = pop_ser ? LOCK_SER : LOCK_PS2;
          else                    last_d  = pop_ser;
        end
      end
      LOCK_PS2, LOCK_SER: begin
        if (state == LOCK_PS2 && !ps2_empty) begin
          pop_ps2 = 1'b1;
          pop_dat = ps2_head;
        end else if (state == LOCK_SER && !ser_empty) begin
          pop_ser = 1'b1;
          pop_dat = ser_head;
        end
        if (pop_ps2 || pop_ser) begin
          if (!is_prefix(pop_dat)) begin
            state_d = IDLE;
            last_d  = pop_ser;
          end
        end else if (to_cnt == TO_LAST) begin
          // Stalled mid-sequence: release the lock and let the decoder reset.
          abort_d = 1'b1;
          state_d = IDLE;
          last_d  = (state == LOCK_SER);
        end else begin
          to_d = to_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kc_dat   <= 8'h00;
      kc_stb   <= 1'b0;
      kc_src   <= 1'b0;
      kc_abort <= 1'b0;
      drop_ps2 <= 1'b0;
      drop_ser <= 1'b0;
    end else begin
      kc_stb   <= pop_ps2 || pop_ser;
      if (pop_ps2 || pop_ser) begin
        kc_dat <= pop_dat;
        kc_src <= pop_ser;
      end
      kc_abort <= abort_d;
      drop_ps2 <= ps2_kc_stb && !ps2_push;
      drop_ser <= ser_kc_stb && !ser_push;
    end
  end

endmodule

// File: tb/tb_fpga_robots_keycode_arbiter.sv
// Directed bench for the key code arbiter; a second instance with a short
// timeout exercises the stalled-prefix abort.
module tb_fpga_robots_keycode_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ps2_kc_dat, ser_kc_dat;
  logic       ps2_kc_stb, ser_kc_stb;

  logic [7:0] kc_dat, t_kc_dat;
  logic       kc_stb, kc_src, kc_abort, drop_ps2, drop_ser;
  logic       t_kc_stb, t_kc_src, t_kc_abort, t_drop_ps2, t_drop_ser;

  int num_checks = 0;
  int num_errors = 0;

  always #5 clk = ~clk;

  fpga_robots_keycode_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ps2_kc_dat(ps2_kc_dat), .ps2_kc_stb(ps2_kc_stb),
    .ser_kc_dat(ser_kc_dat), .ser_kc_stb(ser_kc_stb),
    .kc_dat(kc_dat), .kc_stb(kc_stb), .kc_src(kc_src), .kc_abort(kc_abort),
    .drop_ps2(drop_ps2), .drop_ser(drop_ser)
  );

  fpga_robots_keycode_arbiter #(.FIFO_AW(2), .TIMEOUT_CYCLES(8), .TO_W(4)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .ps2_kc_dat(ps2_kc_dat), .ps2_kc_stb(ps2_kc_stb),
    .ser_kc_dat(ser_kc_dat), .ser_kc_stb(ser_kc_stb),
    .kc_dat(t_kc_dat), .kc_stb(t_kc_stb), .kc_src(t_kc_src), .kc_abort(t_kc_abort),
    .drop_ps2(t_drop_ps2), .drop_ser(t_drop_ser)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    num_checks++;
    assert (obs === exp) else begin
      num_errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one strobe cycle; returns just after the write edge.
  task automatic applyStimulus(input logic p_stb, input logic [7:0] p_dat,
                               input logic s_stb, input logic [7:0] s_dat);
    ps2_kc_stb = p_stb;
    ps2_kc_dat = p_dat;
    ser_kc_stb = s_stb;
    ser_kc_dat = s_dat;
    step();
    ps2_kc_stb = 1'b0;
    ser_kc_stb = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input bit which, input logic estb,
                             input logic [7:0] edat, input logic esrc, input logic eab);
    logic [7:0] d;
    logic st, s, ab;
    d  = which ? t_kc_dat   : kc_dat;
    st = which ? t_kc_stb   : kc_stb;
    s  = which ? t_kc_src   : kc_src;
    ab = which ? t_kc_abort : kc_abort;
    cmp({tag, ".stb"}, {7'd0, st}, {7'd0, estb});
    cmp({tag, ".abort"}, {7'd0, ab}, {7'd0, eab});
    if (estb) begin
      cmp({tag, ".dat"}, d, edat);
      cmp({tag, ".src"}, {7'd0, s}, {7'd0, esrc});
    end
  endtask

  task automatic checkDrop(input string tag, input logic edp, input logic eds);
    cmp({tag, ".drop_ps2"}, {7'd0, drop_ps2}, {7'd0, edp});
    cmp({tag, ".drop_ser"}, {7'd0, drop_ser}, {7'd0, eds});
  endtask

  task automatic checkReset(input string tag);
    cmp({tag, ".dat"}, kc_dat, 8'h00);
    cmp({tag, ".stb"}, {7'd0, kc_stb}, 8'h00);
    cmp({tag, ".src"}, {7'd0, kc_src}, 8'h00);
    cmp({tag, ".abort"}, {7'd0, kc_abort}, 8'h00);
    checkDrop(tag, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    ps2_kc_stb = 1'b0;
    ser_kc_stb = 1'b0;
    ps2_kc_dat = 8'h00;
    ser_kc_dat = 8'h00;
    step();
    step();
    checkReset("reset");
    rst_n = 1'b1;
    step();

    // Single bytes from each source after idle
    applyStimulus(1'b1, 8'h1D, 1'b0, 8'h00);
    checkOutput("ps2_lat1", 0, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    checkOutput("ps2_out", 0, 1'b1, 8'h1D, 1'b0, 1'b0);
    step();
    checkOutput("ps2_after", 0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) step();
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h1B);
    checkOutput("ser_lat1", 0, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    checkOutput("ser_out", 0, 1'b1, 8'h1B, 1'b1, 1'b0);
    step();
    checkOutput("ser_after", 0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Simultaneous arrivals after reset: PS/2 first
    doReset();
    applyStimulus(1'b1, 8'h1C, 1'b1, 8'h23);
    step();
    checkOutput("same_ps2", 0, 1'b1, 8'h1C, 1'b0, 1'b0);
    step();
    checkOutput("same_ser", 0, 1'b1, 8'h23, 1'b1, 1'b0);
    step();
    checkOutput("same_after", 0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Slow E0 F0 74 on PS/2 with a serial byte arriving mid-sequence
    applyStimulus(1'b1, 8'hE0, 1'b0, 8'h00);
    step();
    checkOutput("seq_e0", 0, 1'b1, 8'hE0, 1'b0, 1'b0);
    for (int i = 0; i < 500; i++) begin
      step();
      checkOutput("seq_wait1", 0, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h29);
    for (int i = 0; i < 500; i++) begin
      step();
      checkOutput("seq_wait2", 0, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 8'hF0, 1'b0, 8'h00);
    step();
    checkOutput("seq_f0", 0, 1'b1, 8'hF0, 1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      step();
      checkOutput("seq_wait3", 0, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 8'h74, 1'b0, 8'h00);
    step();
    checkOutput("seq_74", 0, 1'b1, 8'h74, 1'b0, 1'b0);
    step();
    checkOutput("seq_29", 0, 1'b1, 8'h29, 1'b1, 1'b0);
    step();
    checkOutput("seq_after", 0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Lone E0 with an 8-cycle timeout
    doReset();
    applyStimulus(1'b1, 8'hE0, 1'b0, 8'h00);
    step();
    checkOutput("to_e0", 1, 1'b1, 8'hE0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step();
      checkOutput("to_wait", 1, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    step();
    checkOutput("to_abort", 1, 1'b0, 8'h00, 1'b0, 1'b1);
    step();
    checkOutput("to_after", 1, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h29);
    step();
    checkOutput("to_ser", 1, 1'b1, 8'h29, 1'b1, 1'b0);
    step();
    checkOutput("to_ser_after", 1, 1'b0, 8'h00, 1'b0, 1'b0);

    // Locked on serial, PS/2 FIFO overflows by one byte
    doReset();
    applyStimulus(1'b0, 8'h00, 1'b1, 8'hE0);
    step();
    checkOutput("ovf_lock", 0, 1'b1, 8'hE0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h15, 1'b0, 8'h00);
    checkDrop("ovf_p1", 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h16, 1'b0, 8'h00);
    checkDrop("ovf_p2", 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h1E, 1'b0, 8'h00);
    checkDrop("ovf_p3", 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h26, 1'b0, 8'h00);
    checkDrop("ovf_p4", 1'b0, 1'b0);
    checkOutput("ovf_held", 0, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h25, 1'b0, 8'h00);
    checkDrop("ovf_p5", 1'b1, 1'b0);
    step();
    checkDrop("ovf_once", 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h1C);
    checkOutput("ovf_lat", 0, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    checkOutput("ovf_term", 0, 1'b1, 8'h1C, 1'b1, 1'b0);
    step();
    checkOutput("ovf_b0", 0, 1'b1, 8'h15, 1'b0, 1'b0);
    step();
    checkOutput("ovf_b1", 0, 1'b1, 8'h16, 1'b0, 1'b0);
    step();
    checkOutput("ovf_b2", 0, 1'b1, 8'h1E, 1'b0, 1'b0);
    step();
    checkOutput("ovf_b3", 0, 1'b1, 8'h26, 1'b0, 1'b0);
    step();
    checkOutput("ovf_done", 0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset while locked with bytes buffered
    doReset();
    applyStimulus(1'b0, 8'h00, 1'b1, 8'hE0);
    applyStimulus(1'b1, 8'h1B, 1'b1, 8'hF0);
    checkOutput("rst_pre", 0, 1'b1, 8'hE0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkReset("rst_async");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("rst_quiet", 0, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 8'h5A, 1'b0, 8'h00);
    checkOutput("rst_lat1", 0, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    checkOutput("rst_new", 0, 1'b1, 8'h5A, 1'b0, 1'b0);
    step();
    checkOutput("rst_after", 0, 1'b0, 8'h00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/fpga_robots_keycode_arbiter.md
# fpga_robots_keycode_arbiter

Merges the two key code sources, the PS/2 receiver and the serial-port key code stream, into the single key code strobe/data pair that feeds the keyboard lookup-table decoder in the game control logic. Each source gets a small FIFO, so simultaneous arrivals are not lost. A round-robin arbiter keeps prefix sequences (0xE0 extend, 0xF0 break) atomic per source, so one source's prefix never applies to the other source's key. A stall timeout aborts an incomplete prefix sequence so the decoder can clear its prefix state.

## Interface
Parameters:
- FIFO_AW, 2, log2 of per-source FIFO depth (default 4 entries)
- TIMEOUT_CYCLES, 100000, idle cycles allowed mid-sequence before abort
- TO_W, 17, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
- clk  input  1  clock, rising edge active
- rst_n  input  1  reset, asynchronous, active low
- ps2_kc_dat  input  8  PS/2 key code byte
- ps2_kc_stb  input  1  one-cycle pulse when ps2_kc_dat is valid
- ser_kc_dat  input  8  serial-derived key code byte
- ser_kc_stb  input  1  one-cycle pulse when ser_kc_dat is valid
- kc_dat  output  8  merged key code byte
- kc_stb  output  1  one-cycle pulse when kc_dat is valid
- kc_src  output  1  source of current kc_dat: 0 = PS/2, 1 = serial
- kc_abort  output  1  one-cycle pulse telling the decoder to clear its E0/F0 state
- drop_ps2  output  1  one-cycle pulse when a PS/2 byte is discarded because its FIFO is full
- drop_ser  output  1  same, serial FIFO

## Operation
- Two independent FIFOs, depth 2^FIFO_AW, 8 bits wide. A strobe pushes its byte.
- Push while full: the byte is accepted if a pop of that FIFO occurs in the same cycle. Otherwise it is discarded and drop_x pulses on the next cycle.
- Prefix bytes are exactly 0xE0 and 0xF0. All other bytes, including 0xE1, are terminal.
- Arbiter FSM has three states: IDLE, LOCK_PS2, LOCK_SER. Register `last` holds the most recently served source; reset value is serial, so PS/2 wins first.
- IDLE, only one FIFO non-empty: pop from it.
- IDLE, both FIFOs non-empty: pop from the source that is not `last`.
- IDLE, popped byte is a prefix: go to LOCK_<src>.
- IDLE, popped byte is terminal: stay in IDLE and set `last` = src.
- LOCK_x: pop only from FIFO x, at most one byte per cycle. The other FIFO keeps buffering, and drops bytes once full.
- LOCK_x, popped byte is a prefix: stay in LOCK_x. This covers sequences like E0 F0 xx.
- LOCK_x, popped byte is terminal: go to IDLE and set `last` = x.
- Timeout counter: cleared on every pop and outside LOCK states. It increments each cycle while in LOCK_x with FIFO x empty.
- Timeout fires when the counter reaches TIMEOUT_CYCLES - 1 in that condition. Then: pulse kc_abort, go to IDLE, set `last` = x, clear the counter. No byte is emitted in that cycle.
- The timeout pop block applies only to the timeout cycle. From the next cycle normal IDLE arbitration resumes.
- At most one pop per cycle across both FIFOs, which gives one output byte per cycle maximum.

## Timing
- All outputs are registered.
- Reset values (rst_n low, asynchronous): kc_dat 0x00, kc_stb 0, kc_src 0, kc_abort 0, drop_ps2 0, drop_ser 0. FSM goes to IDLE, `last` = serial, both FIFOs empty, counter 0.
- Reset mid-sequence discards all buffered bytes and any held lock. No kc_abort is issued.
- Latency with an empty FIFO and the arbiter free: input strobe in cycle N, write at edge N. The FIFO is non-empty in cycle N+1, the pop happens at edge N+1, and kc_stb/kc_dat/kc_src are valid in cycle N+2.
- Back-to-back strobes on one source produce back-to-back kc_stb pulses after the 2-cycle latency.
- kc_abort and kc_stb are never high in the same cycle.
- Each drop_x pulse is separate for each discarded byte.

## Test plan
- PS/2 0x1D alone, then serial 0x1B alone, each after idle: kc_stb 2 cycles after each strobe, data 0x1D src 0, then 0x1B src 1, no abort.
- Same-cycle strobes, PS/2 0x1C and serial 0x23, after reset: output 0x1C src 0 in cycle N+2, then 0x23 src 1 in cycle N+3.
- PS/2 E0 F0 74 spread over 3000 cycles, serial 0x29 pushed between the bytes: output E0, F0, 74 all src 0 and contiguous in order, then 0x29 src 1.
- PS/2 0xE0 only, TIMEOUT_CYCLES=8: kc_abort pulses exactly once; a following serial 0x29 is emitted with src 1.
- Locked on serial with the PS/2 FIFO at 4 entries and a 5th PS/2 strobe: one drop_ps2 pulse, the 4 buffered bytes are emitted later in order.
- rst_n low for 1 cycle while locked with bytes buffered: all outputs go to 0 immediately, no bytes are emitted afterward, and a new PS/2 byte is served with 2-cycle latency.
